fetch_prefetch_queue: RTL and testbench
=======================================

// Module: fetch_prefetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end for the RV32I pipeline; next generation of the IF stage.
//  Decouples instruction memory (port a) from decode with a DEPTH-entry {pc, instr} prefetch queue.
//  Issues back-to-back fetches on a hold-until-resp interface; supplies PC, PC+4 and instruction to IF/ID.
//  Accepts a redirect (taken branch/jump from EX), flushes the queue and discards any in-flight response.
// PARAMETERS
//  XLEN      32        data/address width
//  DEPTH     4         queue entries; power of 2, >= 2
//  RESET_PC  32'h60    fetch PC after reset
//  CNT_W     16        width of squash statistics counter
// PORTS
//  clk            in   1                  clock, rising edge
//  rst_n          in   1                  reset, asynchronous, active-low
//  read_a         out  1                  instruction read request, held until resp_a
//  address_a      out  XLEN               fetch address, stable while read_a high
//  resp_a         in   1                  memory response, 1-cycle pulse, rdata_a valid
//  rdata_a        in   XLEN               fetched instruction
//  redirect       in   1                  flush and refetch (pcmuxsel)
//  redirect_pc    in   XLEN               new fetch target
//  out_valid      out  1                  queue head valid
//  out_ready      in   1                  decode accepts head (low = stall)
//  out_instr      out  XLEN               head instruction
//  out_pc         out  XLEN               head PC
//  out_pc_plus4   out  XLEN               head PC + 4
//  occupancy      out  $clog2(DEPTH+1)    valid entries in queue
//  squash_count   out  CNT_W              responses discarded after redirect, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, read_a=0, address_a=0, queue empty, out_valid=0, occupancy=0,
//   squash_count=0, fetch_pc=RESET_PC. Outputs settle immediately, not at next edge.
//  fetch_pc: next address to issue; +4 on each issue (mod 2^XLEN wraps); redirect_pc[1:0] forced to 0.
//  FSM: IDLE (no request), BUSY (request live, response kept), SQUASH (request live, response dropped).
//   read_a = (state != IDLE); address_a = registered addr_q; address never changes while read_a=1.
//  pop = out_valid & out_ready; push = resp_a & state==BUSY & ~redirect.
//  room = (occupancy + push - pop) < DEPTH, evaluated this cycle.
//  IDLE: room -> BUSY, addr_q<=fetch_pc, fetch_pc+=4. First read_a one cycle after issue decision.
//  BUSY & resp_a: push {addr_q, rdata_a}; if room issue next (back-to-back, stay BUSY) else IDLE.
//  BUSY & ~resp_a: hold.
//  Redirect (highest priority, any state): queue cleared (occupancy->0, pop and push ignored);
//   if state==IDLE or resp_a this cycle: -> BUSY, addr_q<=redirect_pc, fetch_pc<=redirect_pc+4;
//   else -> SQUASH, fetch_pc<=redirect_pc (later redirect in SQUASH overwrites target).
//  SQUASH & resp_a: drop data, squash_count+=1 (saturate at all-ones), -> BUSY, addr_q<=fetch_pc, fetch_pc+=4.
//   Redirect with resp_a in BUSY also drops that response and increments squash_count.
//  Queue: circular, rd/wr pointers $clog2(DEPTH) wide, natural wrap. out_* driven from head entry
//   combinationally; out_valid = (occupancy != 0), no combinational path from redirect.
//  Full: no issue while room=0; single outstanding request guarantees a slot for its response.
//  Empty: out_valid=0; push to empty queue visible on out_* next cycle (1-cycle resp-to-decode latency).
//  Simultaneous push and pop at full/empty keep occupancy constant; pop of empty queue impossible.
//  Stalled decode (out_ready=0) holds head stable; fetch continues until queue full.
// TESTING
//  Reset, memory answers 1 cycle after each request -> addresses 0x60,0x64,0x68.. in order; out_pc/instr match.
//  out_ready=0, DEPTH=4 -> exactly 4 entries fill, occupancy=4, read_a=0; release -> fetch resumes at 0x70.
//  Redirect to 0x200 while request to 0x68 awaits resp (3-cycle latency) -> 0x68 data dropped,
//   squash_count=1, next address_a=0x200, occupancy 0 until 0x200 returns.
//  Redirect to 0x300 same cycle as resp_a -> that data not queued, address_a=0x300 next cycle, squash_count+1.
//  Two redirects (0x400 then 0x500) during one SQUASH -> only 0x500 fetched; redirect_pc=0x503 fetches 0x500.
//  rst_n low mid-BUSY with 3 entries -> read_a=0, out_valid=0 asynchronously; after release fetch at 0x60.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_queue
// Brief    : RV32I instruction-fetch front end with a DEPTH-entry {pc, instr}
//            prefetch queue, hold-until-resp memory port and redirect squash.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h60,
    parameter int              CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       read_a,
    output logic [XLEN-1:0]            address_a,
    input  logic                       resp_a,
    input  logic [XLEN-1:0]            rdata_a,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           squash_count
);

    localparam int              c_PTR_W      = $clog2(DEPTH);
    localparam int              c_OCC_W      = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] c_INSTR_SZ   = XLEN'(4);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    state_t               r_state;
    logic [XLEN-1:0]      r_addr_q;
    logic [XLEN-1:0]      r_fetch_pc;
    logic [XLEN-1:0]      r_pc_mem    [DEPTH];
    logic [XLEN-1:0]      r_instr_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_OCC_W-1:0]   r_count;
    logic [CNT_W-1:0]     r_squash_count;

    state_t               w_state_nxt;
    logic [XLEN-1:0]      w_addr_nxt;
    logic [XLEN-1:0]      w_fetch_pc_nxt;
    logic                 w_squash_inc;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_room;
    logic [c_OCC_W:0]     w_occ_nxt;
    logic [XLEN-1:0]      w_redir_pc;
    logic [XLEN-1:0]      w_redir_pc_inc;
    logic [XLEN-1:0]      w_fetch_pc_inc;

    assign w_pop          = out_valid & out_ready;
    assign w_push         = resp_a & (r_state == ST_BUSY) & ~redirect;
    assign w_occ_nxt      = {1'b0, r_count} + (c_OCC_W+1)'(w_push) - (c_OCC_W+1)'(w_pop);
    assign w_room         = w_occ_nxt < (c_OCC_W+1)'(DEPTH);
    assign w_redir_pc     = redirect_pc & c_ALIGN_MASK;
    assign w_redir_pc_inc = w_redir_pc + c_INSTR_SZ;
    assign w_fetch_pc_inc = r_fetch_pc + c_INSTR_SZ;

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr_q;
        w_fetch_pc_nxt = r_fetch_pc;
        w_squash_inc   = 1'b0;
        if (redirect) begin
            // Any response arriving with a redirect belongs to the old path.
            w_squash_inc = resp_a & (r_state != ST_IDLE);
            if ((r_state == ST_IDLE) || resp_a) begin
                w_state_nxt    = ST_BUSY;
                w_addr_nxt     = w_redir_pc;
                w_fetch_pc_nxt = w_redir_pc_inc;
            end else begin
                w_state_nxt    = ST_SQUASH;
                w_fetch_pc_nxt = w_redir_pc;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_room) begin
                        w_state_nxt    = ST_BUSY;
                        w_addr_nxt     = r_fetch_pc;
                        w_fetch_pc_nxt = w_fetch_pc_inc;
                    end
                end
                ST_BUSY: begin
                    if (resp_a) begin
                        if (w_room) begin
                            w_addr_nxt     = r_fetch_pc;
                            w_fetch_pc_nxt = w_fetch_pc_inc;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_SQUASH: begin
                    if (resp_a) begin
                        w_squash_inc   = 1'b1;
                        w_state_nxt    = ST_BUSY;
                        w_addr_nxt     = r_fetch_pc;
                        w_fetch_pc_nxt = w_fetch_pc_inc;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_addr_q       <= '0;
            r_fetch_pc     <= RESET_PC;
            r_squash_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr_q   <= w_addr_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            if (w_squash_inc && (r_squash_count != '1)) begin
                r_squash_count <= r_squash_count + CNT_W'(1);
            end
        end
    end

    // Circular queue; DEPTH is a power of two so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc_mem[r_wr_ptr]    <= r_addr_q;
                r_instr_mem[r_wr_ptr] <= rdata_a;
                r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= w_occ_nxt[c_OCC_W-1:0];
        end
    end

    assign read_a       = (r_state != ST_IDLE);
    assign address_a    = r_addr_q;
    assign out_valid    = (r_count != '0);
    assign out_pc       = r_pc_mem[r_rd_ptr];
    assign out_instr    = r_instr_mem[r_rd_ptr];
    assign out_pc_plus4 = out_pc + c_INSTR_SZ;
    assign occupancy    = r_count;
    assign squash_count = r_squash_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch_queue
// Brief    : Self-checking bench for fetch_prefetch_queue with a latency-
//            programmable memory model and an in-order pop scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_queue;

    localparam int              XLEN    = 32;
    localparam int              DEPTH   = 4;
    localparam int              CNT_W   = 3;
    localparam int              OCC_W   = $clog2(DEPTH+1);
    localparam int              c_SAT   = (1 << CNT_W) - 1;
    localparam logic [XLEN-1:0] c_MAGIC = 32'hC0DE_0013;

    logic                clk;
    logic                rst_n;
    logic                read_a;
    logic [XLEN-1:0]     address_a;
    logic                resp_a;
    logic [XLEN-1:0]     rdata_a;
    logic                redirect;
    logic [XLEN-1:0]     redirect_pc;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_instr;
    logic [XLEN-1:0]     out_pc;
    logic [XLEN-1:0]     out_pc_plus4;
    logic [OCC_W-1:0]    occupancy;
    logic [CNT_W-1:0]    squash_count;

    int n_vec  = 0;
    int n_fail = 0;
    int n_pops = 0;
    int mem_lat = 1;
    int exp_sq = 0;
    logic [XLEN-1:0] exp_q[$];

    typedef struct {
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] exp_pc;
        logic [XLEN-1:0] exp_plus4;
    } redir_vec_t;
    redir_vec_t vecs[5];

    fetch_prefetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h60),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_a       (read_a),
        .address_a    (address_a),
        .resp_a       (resp_a),
        .rdata_a      (rdata_a),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .occupancy    (occupancy),
        .squash_count (squash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Advance to just after the falling edge: outputs are stable, inputs safe to drive.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [XLEN-1:0] start);
        for (int k = 0; k < 64; k++) exp_q.push_back(start + 32'(4 * k));
    endtask

    task automatic do_reset();
        cyc();
        rst_n    = 1'b0;
        redirect = 1'b0;
        exp_q.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
        exp_sq = 0;
    endtask

    task automatic apply_redirect(input logic [XLEN-1:0] target, input logic [XLEN-1:0] first);
        redirect    = 1'b1;
        redirect_pc = target;
        exp_q.delete();
        push_seq(first);
    endtask

    task automatic bump_sq();
        exp_sq = (exp_sq >= c_SAT) ? c_SAT : exp_sq + 1;
    endtask

    task automatic wait_resp(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 12 && !ok; k++) begin
            cyc();
            ok = resp_a;
        end
        if (!ok) timeout(name);
    endtask

    task automatic wait_occ_nz(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            cyc();
            ok = (occupancy != '0);
        end
        if (!ok) timeout(name);
    endtask

    task automatic wait_pops(input string name, input int target);
        for (int k = 0; k < 60 && n_pops < target; k++) cyc();
        if (n_pops < target) timeout(name);
    endtask

    task automatic wait_addr(input string name, input logic [XLEN-1:0] addr);
        bit ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            cyc();
            ok = read_a && (address_a == addr);
        end
        if (!ok) timeout(name);
    endtask

    // Memory: holds resp_a for one cycle, mem_lat cycles after read_a is first seen.
    initial begin : mem_model
        int cnt;
        cnt     = 0;
        resp_a  = 1'b0;
        rdata_a = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                resp_a = 1'b0;
                cnt    = 0;
            end else begin
                if (resp_a) begin
                    resp_a = 1'b0;
                    cnt    = 0;
                end
                if (read_a) begin
                    cnt++;
                    if (cnt >= mem_lat) begin
                        resp_a  = 1'b1;
                        rdata_a = address_a ^ c_MAGIC;
                    end
                end
            end
        end
    end

    // Scoreboard: every accepted head must be the next expected fetch address.
    initial begin : pop_monitor
        logic [XLEN-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    timeout("pop_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", out_pc, e);
                    check("pop_instr", out_instr, e ^ c_MAGIC);
                    check("pop_pc_plus4", out_pc_plus4, e + 32'd4);
                    n_pops++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int base;
        vecs[0] = '{target: 32'h0000_1000, exp_pc: 32'h0000_1000, exp_plus4: 32'h0000_1004};
        vecs[1] = '{target: 32'h0000_2002, exp_pc: 32'h0000_2000, exp_plus4: 32'h0000_2004};
        vecs[2] = '{target: 32'hFFFF_FFFC, exp_pc: 32'hFFFF_FFFC, exp_plus4: 32'h0000_0000};
        vecs[3] = '{target: 32'h0000_0007, exp_pc: 32'h0000_0004, exp_plus4: 32'h0000_0008};
        vecs[4] = '{target: 32'h8000_0001, exp_pc: 32'h8000_0000, exp_plus4: 32'h8000_0004};

        rst_n       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_read_a", read_a, 0);
        check("rst_address_a", address_a, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_squash", squash_count, 0);

        // Back-to-back fetch with single-cycle memory.
        out_ready = 1'b1;
        mem_lat   = 1;
        do_reset();
        push_seq(32'h60);
        base = n_pops;
        cyc(); check("b2b_first_read", read_a, 1); check("b2b_addr0", address_a, 32'h60);
        cyc(); check("b2b_addr1", address_a, 32'h64);
        cyc(); check("b2b_addr2", address_a, 32'h68);
        wait_pops("b2b_pops", base + 8);

        // Stalled decode fills the queue, then fetch resumes.
        out_ready = 1'b0;
        do_reset();
        push_seq(32'h60);
        base = n_pops;
        repeat (9) cyc();
        check("full_occ", occupancy, 4);
        check("full_read_a", read_a, 0);
        check("full_valid", out_valid, 1);
        check("full_head_pc", out_pc, 32'h60);
        check("full_head_instr", out_instr, 32'h60 ^ c_MAGIC);
        out_ready = 1'b1;
        cyc();
        check("resume_read_a", read_a, 1);
        check("resume_addr", address_a, 32'h70);
        check("resume_occ", occupancy, 3);
        wait_pops("resume_pops", base + 8);

        // Redirect while a slow request is outstanding.
        mem_lat = 3;
        do_reset();
        push_seq(32'h60);
        wait_addr("sq_wait_68", 32'h68);
        check("sq_count_before", squash_count, 0);
        apply_redirect(32'h200, 32'h200);
        cyc();
        redirect = 1'b0;
        check("sq_read_a", read_a, 1);
        check("sq_addr_held", address_a, 32'h68);
        check("sq_occ", occupancy, 0);
        wait_resp("sq_resp");
        bump_sq();
        cyc();
        check("sq_new_addr", address_a, 32'h200);
        check("sq_count", squash_count, exp_sq);
        check("sq_occ_after", occupancy, 0);
        wait_occ_nz("sq_fill");
        check("sq_first_pc", out_pc, 32'h200);
        check("sq_first_occ", occupancy, 1);

        // Redirect coinciding with a response.
        wait_resp("rr_resp");
        apply_redirect(32'h300, 32'h300);
        bump_sq();
        cyc();
        redirect = 1'b0;
        check("rr_addr", address_a, 32'h300);
        check("rr_read_a", read_a, 1);
        check("rr_count", squash_count, exp_sq);
        check("rr_occ", occupancy, 0);
        wait_occ_nz("rr_fill");
        check("rr_first_pc", out_pc, 32'h300);

        // Two redirects inside one squash window; the later target wins.
        wait_resp("dr_resp");
        cyc();
        apply_redirect(32'h400, 32'h400);
        cyc();
        apply_redirect(32'h503, 32'h500);
        cyc();
        redirect = 1'b0;
        check("dr_read_a", read_a, 1);
        check("dr_occ", occupancy, 0);
        bump_sq();
        cyc();
        check("dr_addr", address_a, 32'h500);
        check("dr_count", squash_count, exp_sq);
        wait_occ_nz("dr_fill");
        check("dr_first_pc", out_pc, 32'h500);

        // Redirect vector table: alignment, address wrap and counter saturation.
        mem_lat = 1;
        for (int i = 0; i < 5; i++) begin
            wait_resp("tbl_resp");
            apply_redirect(vecs[i].target, vecs[i].exp_pc);
            bump_sq();
            cyc();
            redirect = 1'b0;
            check("tbl_addr", address_a, vecs[i].exp_pc);
            check("tbl_count", squash_count, exp_sq);
            wait_occ_nz("tbl_fill");
            check("tbl_pc", out_pc, vecs[i].exp_pc);
            check("tbl_pc_plus4", out_pc_plus4, vecs[i].exp_plus4);
            check("tbl_instr", out_instr, vecs[i].exp_pc ^ c_MAGIC);
            base = n_pops;
            wait_pops("tbl_pops", base + 3);
        end
        check("sat_count", squash_count, c_SAT);

        // Asynchronous reset in BUSY with three entries queued.
        out_ready = 1'b0;
        do_reset();
        begin
            bit ok = 1'b0;
            for (int k = 0; k < 12 && !ok; k++) begin
                cyc();
                ok = (occupancy == 3);
            end
            if (!ok) timeout("ar_fill3");
        end
        check("ar_busy", read_a, 1);
        rst_n = 1'b0;
        #1;
        check("ar_read_a", read_a, 0);
        check("ar_valid", out_valid, 0);
        check("ar_occ", occupancy, 0);
        check("ar_addr", address_a, 0);
        exp_q.delete();
        push_seq(32'h60);
        base = n_pops;
        cyc();
        out_ready = 1'b1;
        rst_n     = 1'b1;
        cyc();
        check("ar_restart_read", read_a, 1);
        check("ar_restart_addr", address_a, 32'h60);
        wait_pops("ar_pops", base + 4);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
